uart_tx_serializer: RTL and testbench
=====================================

UART_TX_SERIALIZER -- requirements
Module: uart_tx_serializer

Interface
REQ-001 The block SHALL have parameter OVERSAMPLE, default 16, giving the number of brc pulses per serial bit.
REQ-002 The block SHALL have port clk, input, 1: the single system clock; all state changes occur on its rising edge.
REQ-003 The block SHALL have port rst, input, 1: asynchronous, active-high reset.
REQ-004 The block SHALL have port brc, input, 1: baud-rate clock enable, one clk wide, OVERSAMPLE pulses per bit.
REQ-005 The block SHALL have port d, input, 8: parallel transmit data, LSB sent first.
REQ-006 The block SHALL have port d_valid, input, 1: d and config are valid this cycle.
REQ-007 The block SHALL have port d_ready, output, 1: the block accepts a word this cycle.
REQ-008 The block SHALL have port wlen, input, 2: data bits per word, where 0=5, 1=6, 2=7 and 3=8.
REQ-009 The block SHALL have port par_en, input, 1: a parity bit is appended.
REQ-010 The block SHALL have port par_even, input, 1: 1 selects even parity and 0 selects odd parity.
REQ-011 The block SHALL have port stop2, input, 1: 1 selects two stop bits and 0 selects one stop bit.
REQ-012 The block SHALL have port brk, input, 1: line break, which forces sdo low.
REQ-013 The block SHALL have port sdo, output, 1: serial data out, idle high.
REQ-014 The block SHALL have port busy, output, 1: a frame is in progress.

Function
REQ-015 A transfer SHALL occur on a clk edge where d_valid=1 and d_ready=1.
- d, wlen, par_en, par_even and stop2 are latched at that edge.
- Later changes on these inputs do not affect the frame in flight.
REQ-016 d_ready SHALL be 1 only in state IDLE and SHALL be 0 in every other state.
REQ-017 The state machine SHALL have states IDLE, START, DATA, PARITY, STOP1 and STOP2.
REQ-018 IDLE -> START SHALL occur on a transfer; the other transitions are:
- START -> DATA.
- DATA -> PARITY when par_en=1, otherwise DATA -> STOP1.
- PARITY -> STOP1.
- STOP1 -> STOP2 when stop2=1, otherwise STOP1 -> IDLE.
- STOP2 -> IDLE.
REQ-019 Bit timing SHALL use a counter that clears to 0 on every state entry and increments on each brc.
- The counter advances the state, or the data bit within DATA, on the brc at which it reads OVERSAMPLE-1.
- Each serial bit therefore lasts exactly OVERSAMPLE brc pulses.
REQ-020 DATA SHALL send latched bits 0 to (wlen+4), LSB first; bits above wlen+4 are ignored.
REQ-021 The parity bit SHALL be the XOR of the transmitted data bits when par_even=1, and the inverse of that XOR when par_even=0.
REQ-022 sdo SHALL be a registered output with these values:
- 1 in IDLE and in the STOP states.
- 0 in START.
- The current data bit in DATA.
- The parity bit in PARITY.
REQ-023 sdo SHALL change only on the clk edge that causes a state or bit change.
REQ-024 While brk=1, sdo SHALL be 0 regardless of state, and the state machine and counter SHALL continue unchanged.
REQ-025 busy SHALL be 1 in every state except IDLE.
REQ-026 After a frame ends, the block SHALL spend at least one clk in IDLE, with sdo=1, before the next START.
REQ-027 brc pulses that arrive while in IDLE SHALL be ignored.

Reset
REQ-028 While rst=1, the block SHALL force state IDLE, counter 0, sdo=1, busy=0 and d_ready=1, and SHALL clear the latched word and config to 0.
REQ-029 Assertion of rst mid-frame SHALL abort the frame immediately, asynchronously, with no partial stop bit.
REQ-030 After rst is released, the first transfer SHALL start a fresh frame.

Structure
REQ-031 A shared package SHALL define:
- The state enum, with one value per state in REQ-017.
- The wlen encoding constants.
- The OVERSAMPLE default.
REQ-032 The bit-timing counter SHALL be a sub-module named uart_baud_tick_counter with these ports:
- clk, rst, clear and brc as inputs.
- A tick output that pulses on the OVERSAMPLE-th brc.

Verification
REQ-033 With brc=1 every cycle and 8N1, sending d=0x55 SHALL produce sdo 0,1,0,1,0,1,0,1,0,1 at 16 clk per bit, with busy=1 for 160 clk.
REQ-034 With 7 data bits, even parity and 2 stop bits, sending d=0xA3 SHALL produce sdo 0,1,1,0,0,0,1,0,1,1,1, 11 bits (176 brc), with bit 7 ignored.
REQ-035 With 5 data bits and odd parity, sending d=0x1F SHALL produce sdo 0,1,1,1,1,1,0,1.
REQ-036 With brc every 4th clk, sending 0x00 as 8N1 SHALL produce a start bit lasting 64 clk.
REQ-037 Holding d_valid=1 for two bytes (0x01, 0x80) SHALL produce two frames separated by exactly one idle clk.
REQ-038 When brk=1 is asserted during STOP1, sdo SHALL go to 0 and busy SHALL fall on schedule.
REQ-039 When rst is asserted mid-DATA, sdo SHALL go to 1 at once, and a new 0x3C after rst is released SHALL be sent correctly.

Source files
------------

// File: rtl/uart_tx_serializer_pkg.sv
// Shared types and constants for the UART transmit serializer.
// Frame FSM states, word-length codes and oversampling default.
`timescale 1ns/1ps
package uart_tx_serializer_pkg;

  typedef enum logic [2:0] {
    S_IDLE,
    S_START,
    S_DATA,
    S_PARITY,
    S_STOP1,
    S_STOP2
  } state_t;

  localparam logic [1:0] WLEN_5 = 2'd0;
  localparam logic [1:0] WLEN_6 = 2'd1;
  localparam logic [1:0] WLEN_7 = 2'd2;
  localparam logic [1:0] WLEN_8 = 2'd3;

  localparam int OVERSAMPLE_DEF = 16;

  // Index of the last data bit sent for a word-length code.
  function automatic logic [2:0] last_bit(input logic [1:0] wlen);
    return {1'b0, wlen} + 3'd4;
  endfunction

  // Keeps only the bits that are actually transmitted.
  function automatic logic [7:0] data_mask(input logic [1:0] wlen);
    logic [7:0] m;
    case (wlen)
      WLEN_5:  m = 8'h1f;
      WLEN_6:  m = 8'h3f;
      WLEN_7:  m = 8'h7f;
      default: m = 8'hff;
    endcase
    return m;
  endfunction

endpackage

// File: rtl/uart_tx_serializer_tick.sv
// Bit-timing counter: counts brc pulses, ticks on the OVERSAMPLE-th.
// Ports: clk, rst (async high), clear, brc in; tick out.
`timescale 1ns/1ps
module uart_baud_tick_counter #(
  parameter int OVERSAMPLE = 16
) (
  input  logic clk,
  input  logic rst,
  input  logic clear,
  input  logic brc,
  output logic tick
);

  localparam int CW = (OVERSAMPLE > 1) ? $clog2(OVERSAMPLE) : 1;
  localparam logic [CW-1:0] LAST = CW'(OVERSAMPLE - 1);

  logic [CW-1:0] cnt;

  assign tick = brc & ~clear & (cnt == LAST);

  // Wrapping on tick doubles as the clear on every state/bit entry.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt <= '0;
    end else if (clear || tick) begin
      cnt <= '0;
    end else if (brc) begin
      cnt <= cnt + CW'(1);
    end
  end

endmodule

// File: rtl/uart_tx_serializer.sv
// UART transmitter: latches a word on handshake, shifts it out LSB first.
// Ports: clk, rst, brc, d/d_valid/d_ready, wlen, par_en, par_even, stop2, brk, sdo, busy.
`timescale 1ns/1ps
module uart_tx_serializer
  import uart_tx_serializer_pkg::*;
#(
  parameter int OVERSAMPLE = OVERSAMPLE_DEF
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       brc,
  input  logic [7:0] d,
  input  logic       d_valid,
  output logic       d_ready,
  input  logic [1:0] wlen,
  input  logic       par_en,
  input  logic       par_even,
  input  logic       stop2,
  input  logic       brk,
  output logic       sdo,
  output logic       busy
);

  state_t     state;
  logic [7:0] data;
  logic [1:0] wl;
  logic       pen;
  logic       st2;
  logic       pbit;
  logic [2:0] idx;
  logic [2:0] idx_nx;
  logic       last;
  logic       line;
  logic       line_n;
  logic       clear;
  logic       tick;

  assign clear   = (state == S_IDLE);
  assign d_ready = clear;
  assign busy    = ~clear;
  assign idx_nx  = idx + 3'd1;
  assign last    = (idx == last_bit(wl));

  uart_baud_tick_counter #(
    .OVERSAMPLE(OVERSAMPLE)
  ) u_tick (
    .clk  (clk),
    .rst  (rst),
    .clear(clear),
    .brc  (brc),
    .tick (tick)
  );

  // Unbroken line level after this edge; moves only on a state/bit change.
  always_comb begin
    line_n = line;
    if (state == S_IDLE) begin
      if (d_valid) line_n = 1'b0;
    end else if (tick) begin
      unique case (state)
        S_START: line_n = data[0];
        S_DATA:  line_n = last ? (pen ? pbit : 1'b1) : data[idx_nx];
        default: line_n = 1'b1;
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= S_IDLE;
      data  <= '0;
      wl    <= '0;
      pen   <= 1'b0;
      st2   <= 1'b0;
      pbit  <= 1'b0;
      idx   <= '0;
      line  <= 1'b1;
      sdo   <= 1'b1;
    end else begin
      line <= line_n;
      sdo  <= line_n & ~brk;
      unique case (state)
        S_IDLE: if (d_valid) begin
          state <= S_START;
          data  <= d;
          wl    <= wlen;
          pen   <= par_en;
          st2   <= stop2;
          pbit  <= ^(d & data_mask(wlen)) ^ ~par_even;
          idx   <= '0;
        end
        S_START: if (tick) begin
          state <= S_DATA;
          idx   <= '0;
        end
        S_DATA: if (tick) begin
          if (last) state <= pen ? S_PARITY : S_STOP1;
          else      idx   <= idx_nx;
        end
        S_PARITY: if (tick) state <= S_STOP1;
        S_STOP1:  if (tick) state <= st2 ? S_STOP2 : S_IDLE;
        S_STOP2:  if (tick) state <= S_IDLE;
        default:  state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_uart_tx_serializer.sv
// Self-checking bench for uart_tx_serializer.
// Table of frames plus hand sequences for back-to-back, break and reset.
`timescale 1ns/1ps
module tb_uart_tx_serializer;

  logic       clk = 1'b0;
  logic       rst;
  logic       brc;
  logic [7:0] d;
  logic       d_valid;
  logic       d_ready;
  logic [1:0] wlen;
  logic       par_en;
  logic       par_even;
  logic       stop2;
  logic       brk;
  logic       sdo;
  logic       busy;

  uart_tx_serializer #(.OVERSAMPLE(16)) dut (
    .clk     (clk),
    .rst     (rst),
    .brc     (brc),
    .d       (d),
    .d_valid (d_valid),
    .d_ready (d_ready),
    .wlen    (wlen),
    .par_en  (par_en),
    .par_even(par_even),
    .stop2   (stop2),
    .brk     (brk),
    .sdo     (sdo),
    .busy    (busy)
  );

  always #5 clk = ~clk;

  // frame: transmitted bits, first bit in frame[11], nb bits used.
  typedef struct {
    logic [7:0]  d;
    logic [1:0]  wlen;
    logic        pe;
    logic        pev;
    logic        s2;
    int          div;
    logic [11:0] frame;
    int          nb;
  } vec_t;

  vec_t vecs[6];
  logic q[$];
  int   tests = 0;
  int   fails = 0;
  int   t = 0;
  int   div = 1;

  task automatic chk(input string name, input logic got, input logic exp);
    tests++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s t=%0d got=%b exp=%b", name, t, got, exp);
    end
  endtask

  // Advance one clk; brc is set up for the following edge.
  task automatic step();
    @(posedge clk);
    #1;
    t++;
    brc = (((t + 1) % div) == 0);
  endtask

  task automatic push_bits(input logic [11:0] f, input int n);
    for (int i = 0; i < n; i++) q.push_back(f[11-i]);
  endtask

  // Drives a word and completes the handshake; afterwards t=0 is the
  // transfer edge.
  task automatic start_frame(input vec_t v, input int npush);
    int guard;
    div      = v.div;
    d        = v.d;
    wlen     = v.wlen;
    par_en   = v.pe;
    par_even = v.pev;
    stop2    = v.s2;
    d_valid  = 1'b1;
    push_bits(v.frame, npush);
    guard = 0;
    while (!d_ready && guard < 1000) begin
      step();
      guard++;
    end
    chk("ready_before_xfer", d_ready, 1'b1);
    t   = -1;
    brc = 1'b1;
    step();
  endtask

  // Inputs change after the transfer; the frame must not notice.
  task automatic scramble();
    d        = ~d;
    wlen     = ~wlen;
    par_en   = ~par_en;
    par_even = ~par_even;
    stop2    = ~stop2;
    d_valid  = 1'b0;
  endtask

  task automatic expect_frame(input int nb, input int nchk, input bit endchk);
    int   dur;
    logic e;
    dur = 16 * div;
    for (int k = 0; k < nchk; k++) begin
      while (t < k * dur + dur / 2) step();
      if (q.size() == 0) begin
        tests++;
        fails++;
        $display("FAIL queue_empty t=%0d got=none exp=bit", t);
      end else begin
        e = q.pop_front();
        chk("sdo_bit", sdo, e);
      end
    end
    if (endchk) begin
      while (t < nb * dur - 1) step();
      chk("busy_last_clk", busy, 1'b1);
      step();
      chk("busy_end", busy, 1'b0);
      chk("sdo_idle", sdo, 1'b1);
      chk("ready_idle", d_ready, 1'b1);
    end
  endtask

  initial begin
    vec_t a;
    vec_t b;
    vec_t v;
    rst      = 1'b1;
    brc      = 1'b1;
    d_valid  = 1'b0;
    d        = 8'h00;
    wlen     = 2'd0;
    par_en   = 1'b0;
    par_even = 1'b0;
    stop2    = 1'b0;
    brk      = 1'b0;

    vecs[0] = '{8'h55, 2'd3, 1'b0, 1'b0, 1'b0, 1, 12'b010101010100, 10};
    vecs[1] = '{8'ha3, 2'd2, 1'b1, 1'b1, 1'b1, 1, 12'b011000101110, 11};
    vecs[2] = '{8'h1f, 2'd0, 1'b1, 1'b0, 1'b0, 1, 12'b011111010000, 8};
    vecs[3] = '{8'hc6, 2'd1, 1'b1, 1'b0, 1'b0, 1, 12'b001100011000, 9};
    vecs[4] = '{8'hff, 2'd3, 1'b1, 1'b1, 1'b1, 1, 12'b011111111011, 12};
    vecs[5] = '{8'h00, 2'd3, 1'b0, 1'b0, 1'b0, 4, 12'b000000000100, 10};

    repeat (3) @(posedge clk);
    #1;
    chk("rst_sdo", sdo, 1'b1);
    chk("rst_busy", busy, 1'b0);
    chk("rst_ready", d_ready, 1'b1);
    rst = 1'b0;
    repeat (20) step();
    chk("idle_sdo", sdo, 1'b1);
    chk("idle_busy", busy, 1'b0);

    for (int i = 0; i < 6; i++) begin
      start_frame(vecs[i], vecs[i].nb);
      scramble();
      expect_frame(vecs[i].nb, vecs[i].nb, 1'b1);
      repeat (3) step();
    end

    // Back-to-back words with d_valid held high.
    a = '{8'h01, 2'd3, 1'b0, 1'b0, 1'b0, 1, 12'b010000000100, 10};
    b = '{8'h80, 2'd3, 1'b0, 1'b0, 1'b0, 1, 12'b000000001100, 10};
    start_frame(a, 10);
    d = 8'h80;
    push_bits(b.frame, 10);
    expect_frame(10, 10, 1'b1);
    step();
    t = 0;
    chk("b2b_one_idle", busy, 1'b1);
    d_valid = 1'b0;
    expect_frame(10, 10, 1'b1);
    repeat (3) step();

    // Break during STOP1: line forced low, timing untouched.
    v = vecs[0];
    start_frame(v, 9);
    scramble();
    expect_frame(10, 9, 1'b0);
    while (t < 148) step();
    brk = 1'b1;
    step();
    step();
    chk("brk_sdo", sdo, 1'b0);
    chk("brk_busy", busy, 1'b1);
    while (t < 159) step();
    chk("brk_busy_last", busy, 1'b1);
    step();
    chk("brk_busy_end", busy, 1'b0);
    chk("brk_sdo_idle", sdo, 1'b0);
    brk = 1'b0;
    step();
    chk("brk_release", sdo, 1'b1);
    repeat (3) step();

    // Reset in the middle of DATA.
    v = '{8'hff, 2'd3, 1'b0, 1'b0, 1'b0, 1, 12'b011111111100, 10};
    start_frame(v, 3);
    scramble();
    expect_frame(10, 3, 1'b0);
    while (t < 50) step();
    chk("pre_rst_busy", busy, 1'b1);
    rst = 1'b1;
    #1;
    chk("mid_rst_sdo", sdo, 1'b1);
    chk("mid_rst_busy", busy, 1'b0);
    chk("mid_rst_ready", d_ready, 1'b1);
    repeat (2) step();
    rst = 1'b0;
    repeat (5) step();
    v = '{8'h3c, 2'd3, 1'b0, 1'b0, 1'b0, 1, 12'b000111100100, 10};
    start_frame(v, 10);
    scramble();
    expect_frame(10, 10, 1'b1);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
